triangle_fifo: RTL



---
 rtl/triangle_fifo.sv | 57 +++++
 1 files changed

// File: rtl/triangle_fifo.sv
// triangle_fifo: assembles 60-byte command records into 480-bit words and queues DEPTH of them
module triangle_fifo #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   triangle_wrdata,
  input  logic         triangle_push,
  output logic         triangle_full,
  output logic [479:0] tri_data,
  output logic         tri_efb,
  output logic         tri_ef,
  output logic         tri_valid,
  input  logic         tri_pop,
  output logic         overflow_err
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [479:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rec_count;
  logic [5:0]    byte_cnt;
  logic [8:0]    lsb;
  logic          discard, pop, last, drop, commit;
  always_comb begin
    pop = tri_pop && tri_valid;
    last = triangle_push && byte_cnt == 6'd59;
    drop = triangle_push && byte_cnt == 6'd0 && rec_count == CW'(DEPTH) && !pop;
    commit = last && !discard;
    lsb = 9'(8 * (6'd59 - byte_cnt));
    tri_valid = rec_count != '0;
    tri_data = mem[rd_ptr];
    tri_efb = tri_data[247];
    tri_ef = tri_data[246];
    triangle_full = (CW+1)'(rec_count) + (CW+1)'(byte_cnt != 6'd0 || discard) >= (CW+1)'(DEPTH);
  end
  always_ff @(posedge clk)
    if (triangle_push && !discard && !drop) mem[wr_ptr][lsb +: 8] <= triangle_wrdata;
  always_ff @(posedge clk)
    if (rst) begin
      byte_cnt <= '0;
      discard <= 1'b0;
      overflow_err <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rec_count <= '0;
    end else begin
      if (triangle_push) byte_cnt <= last ? 6'd0 : byte_cnt + 6'd1;
      if (drop) begin
        discard <= 1'b1;
        overflow_err <= 1'b1;
      end else if (last) discard <= 1'b0;
      if (commit) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      if (commit != pop) rec_count <= commit ? rec_count + 1'b1 : rec_count - 1'b1;
    end
endmodule
